// File: rtl/rv3n_trap_csr_if.sv
// func_csr request/ack bundle between the issue stage (master) and the CSR/trap unit (slave).
// Single-beat request, no ready; the master holds off issue while ack_busy is high.
interface rv3n_trap_csr_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [7:0]      req_para;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_operand0;
    logic [XLEN-1:0] req_operand1;
    logic            ack_valid;
    logic [XLEN-1:0] ack_data;
    logic            ack_busy;

    modport master (
        output req_valid, req_para, req_pc, req_operand0, req_operand1,
        input  ack_valid, ack_data, ack_busy
    );

    modport slave (
        input  req_valid, req_para, req_pc, req_operand0, req_operand1,
        output ack_valid, ack_data, ack_busy
    );
endinterface

// File: rtl/rv3n_trap_csr.sv
// Machine-mode CSR file, trap/interrupt entry and root redirect for the rv3n core.
// Latency: CSR/system ack at T+2, redirect at T+1; jcond passes through combinationally.
// Backpressure: ack_busy high for the cycle after acceptance; issue must stall on it.
module rv3n_trap_csr #(
    parameter int          XLEN       = 32,
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] START_ADDR = 32'h200,
    parameter int          TIME_DIV   = 100,
    parameter int          NUM_IRQ    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rv3n_trap_csr_if.slave     func_csr,
    input  logic               jump_jcond_valid,
    input  logic [XLEN-1:0]    jump_jcond_pc,
    input  logic [NUM_IRQ-1:0] irq_ext,
    input  logic               int_ready,
    input  logic [XLEN-1:0]    int_pc,
    output logic               jump_valid,
    output logic [XLEN-1:0]    jump_pc,
    output logic               stage_id_clear
);
    localparam int          PW       = $clog2(TIME_DIV);
    localparam logic [31:0] MIE_MASK = 32'h80 | (((32'd1 << NUM_IRQ) - 32'd1) << 16);

    // architectural state
    logic        st_mie, st_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0] mcycle_q, mtime_q, mtimecmp_q;
    logic [PW-1:0] presc_q;

    // pipeline state
    logic        root_vld_q, wr_q, sys_q, ack_vld_q;
    logic [31:0] root_pc_q, wr_opnd_q, old_q, ack_dat_q;
    logic [11:0] wr_addr_q;
    logic [1:0]  wr_func_q;

    logic [31:0] instr, rdata, mip, pend, wdata, root_pc, trap_epc, trap_cause, tvec_base;
    logic [11:0] cmd_addr;
    logic [2:0]  cmd_func;
    logic [4:0]  cmd_uimm, irq_cause;
    logic        csr_go, sys_go, busy, illegal, is_mret, is_ecall, is_fence_i;
    logic        irq_take, root_vld, trap, do_mret, wr_en, unused_para;

    assign instr       = func_csr.req_operand1;
    assign cmd_addr    = instr[31:20];
    assign cmd_func    = instr[14:12];
    assign cmd_uimm    = instr[19:15];
    assign csr_go      = func_csr.req_valid & func_csr.req_para[4] & ~func_csr.req_para[5];
    assign sys_go      = func_csr.req_valid & func_csr.req_para[5];
    assign illegal     = func_csr.req_para[2:1] != 2'b00;
    assign is_mret     = instr == 32'h3020_0073;
    assign is_ecall    = instr == 32'h0000_0073;
    assign is_fence_i  = (instr[6:0] == 7'h0F) && (cmd_func == 3'b001);
    assign unused_para = ^{func_csr.req_para[7:6], func_csr.req_para[3], func_csr.req_para[0]};
    assign busy        = wr_q | sys_q;
    assign tvec_base   = {mtvec_q[31:2], 2'b00};

    always_comb begin
        mip = '0;
        mip[7] = mtime_q >= mtimecmp_q;
        mip[16 +: NUM_IRQ] = irq_ext;
    end

    assign pend     = mip & mie_q;
    assign irq_take = st_mie & (|pend) & int_ready & ~func_csr.req_valid & ~busy;

    // lowest external line wins, so walk downward and let the last hit stick
    always_comb begin
        irq_cause = 5'd7;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[16 + i]) irq_cause = 5'(16 + i);
    end

    always_comb begin
        rdata = '0;
        case (cmd_addr)
            12'h300: rdata = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
            12'h304: rdata = mie_q;
            12'h305: rdata = mtvec_q;
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'h344: rdata = mip;
            12'hF14: rdata = HART_ID;
            12'hC00: rdata = mcycle_q[31:0];
            12'hC80: rdata = mcycle_q[63:32];
            12'hC01: rdata = mtime_q[31:0];
            12'hC81: rdata = mtime_q[63:32];
            12'h7C0: rdata = mtimecmp_q[31:0];
            12'h7C1: rdata = mtimecmp_q[63:32];
            default: rdata = '0;
        endcase
    end

    always_comb begin
        wdata = old_q;
        case (wr_func_q)
            2'd1:    wdata = wr_opnd_q;
            2'd2:    wdata = old_q | wr_opnd_q;
            2'd3:    wdata = old_q & ~wr_opnd_q;
            default: wdata = old_q;
        endcase
    end
    assign wr_en = wr_q && (wr_func_q != 2'd0);

    always_comb begin
        root_vld   = 1'b0;
        root_pc    = '0;
        trap       = 1'b0;
        do_mret    = 1'b0;
        trap_epc   = '0;
        trap_cause = '0;
        if (sys_go) begin
            root_vld = 1'b1;
            if (!illegal && is_mret) begin
                do_mret = 1'b1;
                root_pc = mepc_q;
            end else if (!illegal && is_fence_i) begin
                root_pc = func_csr.req_pc + 32'd4;
            end else begin
                trap       = 1'b1;
                trap_epc   = func_csr.req_pc;
                trap_cause = (!illegal && is_ecall) ? 32'd11 : 32'd2;
                root_pc    = tvec_base;
            end
        end else if (irq_take) begin
            root_vld   = 1'b1;
            trap       = 1'b1;
            trap_epc   = int_pc;
            trap_cause = {1'b1, 26'd0, irq_cause};
            root_pc    = (mtvec_q[1:0] == 2'b01) ? tvec_base + {25'd0, irq_cause, 2'b00} : tvec_base;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_vld_q <= 1'b1;
            root_pc_q  <= START_ADDR;
            wr_q       <= 1'b0;
            sys_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_func_q  <= '0;
            wr_opnd_q  <= '0;
            old_q      <= '0;
            ack_vld_q  <= 1'b0;
            ack_dat_q  <= '0;
        end else begin
            root_vld_q <= root_vld;
            root_pc_q  <= root_pc;
            wr_q       <= csr_go;
            sys_q      <= sys_go;
            if (csr_go) begin
                wr_addr_q <= cmd_addr;
                wr_func_q <= cmd_func[1:0];
                wr_opnd_q <= cmd_func[2] ? {27'd0, cmd_uimm} : func_csr.req_operand0;
                old_q     <= rdata;
            end
            ack_vld_q <= busy;
            ack_dat_q <= wr_q ? old_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
            if (presc_q == PW'(TIME_DIV - 1)) begin
                presc_q <= '0;
                mtime_q <= mtime_q + 64'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            if (wr_en) begin
                case (wr_addr_q)
                    12'h300: begin
                        st_mie  <= wdata[3];
                        st_mpie <= wdata[7];
                    end
                    12'h304: mie_q            <= wdata & MIE_MASK;
                    12'h305: mtvec_q          <= wdata;
                    12'h340: mscratch_q       <= wdata;
                    12'h341: mepc_q           <= {wdata[31:2], 2'b00};
                    12'h342: mcause_q         <= wdata;
                    12'hC00: mcycle_q[31:0]   <= wdata;
                    12'hC80: mcycle_q[63:32]  <= wdata;
                    12'h7C0: mtimecmp_q[31:0] <= wdata;
                    12'h7C1: mtimecmp_q[63:32] <= wdata;
                    default: ;
                endcase
            end
            if (trap) begin
                mepc_q   <= trap_epc & ~32'h3;
                mcause_q <= trap_cause;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end
            if (do_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

    assign func_csr.ack_valid = ack_vld_q;
    assign func_csr.ack_data  = ack_dat_q;
    assign func_csr.ack_busy  = busy;
    assign jump_valid         = root_vld_q | jump_jcond_valid;
    assign jump_pc            = root_vld_q ? root_pc_q : jump_jcond_pc;
    assign stage_id_clear     = jump_valid;
endmodule

// File: tb/tb_rv3n_trap_csr.sv
// Bench for rv3n_trap_csr: directed trap/interrupt scenarios plus random CSR traffic
// scored against a plain-arithmetic CSR model (time = cycles since reset / TIME_DIV).
module tb_rv3n_trap_csr;
    localparam int          TD   = 2;
    localparam int          NIRQ = 4;
    localparam logic [31:0] HID  = 32'h0000_005A;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv3n_trap_csr_if #(.XLEN(32)) bus();
    logic            jcond_vld, int_ready, jump_valid, stage_id_clear;
    logic [31:0]     jcond_pc, int_pc, jump_pc;
    logic [NIRQ-1:0] irq_ext;

    rv3n_trap_csr #(
        .XLEN(32), .HART_ID(HID), .START_ADDR(32'h200), .TIME_DIV(TD), .NUM_IRQ(NIRQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .func_csr(bus),
        .jump_jcond_valid(jcond_vld), .jump_jcond_pc(jcond_pc),
        .irq_ext(irq_ext), .int_ready(int_ready), .int_pc(int_pc),
        .jump_valid(jump_valid), .jump_pc(jump_pc), .stage_id_clear(stage_id_clear)
    );

    int n_total = 0;
    int n_bad   = 0;

    // cycles since reset release: the definition of mcycle, and mtime = edges / TD
    logic [63:0] edges;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= '0;
        else        edges <= edges + 64'd1;

    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mtimecmp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [63:0] t;
        logic [31:0] mip;
        t   = edges / 64'(TD);
        mip = {12'd0, irq_ext, 16'd0} | ((t >= m_mtimecmp) ? 32'h80 : 32'h0);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return mip;
            12'hF14: return HID;
            12'hC01: return t[31:0];
            12'hC81: return t[63:32];
            12'h7C0: return m_mtimecmp[31:0];
            12'h7C1: return m_mtimecmp[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] w);
        case (a)
            12'h300: m_mstatus  = w & 32'h88;
            12'h304: m_mie      = w & 32'h000F_0080;
            12'h305: m_mtvec    = w;
            12'h340: m_mscratch = w;
            12'h341: m_mepc     = w & ~32'h3;
            12'h342: m_mcause   = w;
            12'h7C0: m_mtimecmp[31:0]  = w;
            12'h7C1: m_mtimecmp[63:32] = w;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        jcond_vld = 1'b0;
        int_ready = 1'b0;
        irq_ext   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_mstatus = '0; m_mie = '0; m_mtvec = '0; m_mscratch = '0;
        m_mepc = '0; m_mcause = '0; m_mtimecmp = '1;
    endtask

    task automatic csr_op(input string tag, input logic [11:0] a, input logic [2:0] f,
                          input logic [31:0] rs1, input logic [4:0] uimm, input logic [31:0] exp);
        bus.req_valid    = 1'b1;
        bus.req_para     = 8'h10;
        bus.req_pc       = 32'h0;
        bus.req_operand0 = rs1;
        bus.req_operand1 = {a, uimm, f, 5'd1, 7'h73};
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check({tag, ".busy"}, 64'(bus.ack_busy), 64'd1);
        @(posedge clk); #1;
        check({tag, ".ack"}, {31'd0, bus.ack_valid, bus.ack_data}, {32'd1, exp});
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_op(tag, a, 3'd6, 32'd0, 5'd0, exp);
    endtask

    task automatic sys_op(input string tag, input logic [7:0] para, input logic [31:0] pc,
                          input logic [31:0] instr, input logic [31:0] exp_pc, input bit with_jcond);
        bus.req_valid    = 1'b1;
        bus.req_para     = para;
        bus.req_pc       = pc;
        bus.req_operand0 = 32'h0;
        bus.req_operand1 = instr;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (with_jcond) begin
            jcond_vld = 1'b1;
            jcond_pc  = 32'h0000_BAD0;
            #1;
        end
        check({tag, ".jump"}, {30'd0, jump_valid, stage_id_clear, jump_pc}, {32'h3, exp_pc});
        check({tag, ".busy"}, 64'(bus.ack_busy), 64'd1);
        jcond_vld = 1'b0;
        @(posedge clk); #1;
        check({tag, ".ack"}, {31'd0, bus.ack_valid, bus.ack_data}, {32'd1, 32'd0});
    endtask

    task automatic wait_irq(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        while (!jump_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".seen"}, 64'(jump_valid), 64'd1);
        check({tag, ".pc"}, 64'(jump_pc), 64'(exp_pc));
        check({tag, ".noack"}, 64'(bus.ack_valid), 64'd0);
        int_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [11:0] addrs [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                12'hF14, 12'hC01, 12'hC81, 12'h7C0, 12'h7C1, 12'h123, 12'h7FF};
    logic [2:0]  fsel [6]   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    initial begin
        logic [11:0] a;
        logic [2:0]  f;
        logic [4:0]  u;
        logic [31:0] rs1, exp, opnd, w;
        int          hits;

        bus.req_valid = 1'b0; bus.req_para = '0; bus.req_pc = '0;
        bus.req_operand0 = '0; bus.req_operand1 = '0;
        jcond_vld = 1'b0; jcond_pc = '0; irq_ext = '0; int_ready = 1'b0; int_pc = '0;

        do_reset();
        check("rst.jump", {30'd0, jump_valid, stage_id_clear, jump_pc}, {32'h3, 32'h200});
        check("rst.ack", {30'd0, bus.ack_valid, bus.ack_busy, bus.ack_data}, 64'd0);
        @(posedge clk); #1;
        check("rst.jump_once", 64'(jump_valid), 64'd0);

        rd("hartid", 12'hF14, HID);
        rd("mcycle", 12'hC00, edges[31:0]);
        csr_op("scr_w", 12'h340, 3'd1, 32'hDEAD_BEEF, 5'd0, 32'h0);
        csr_op("scr_si", 12'h340, 3'd6, 32'h0, 5'h10, 32'hDEAD_BEEF);
        rd("scr_rd", 12'h340, 32'hDEAD_BEFF);

        irq_ext = 4'b1010;
        csr_op("mip_c", 12'h344, 3'd3, 32'hFFFF_FFFF, 5'd0, 32'h000A_0000);
        rd("mip_rd", 12'h344, 32'h000A_0000);
        irq_ext = '0;

        csr_op("mtvec_w", 12'h305, 3'd1, 32'h1000, 5'd0, 32'h0);
        csr_op("mie_on", 12'h300, 3'd6, 32'h0, 5'd8, 32'h0);
        sys_op("ecall", 8'h20, 32'h300, 32'h0000_0073, 32'h1000, 1'b1);
        rd("ecall.mepc", 12'h341, 32'h300);
        rd("ecall.mcause", 12'h342, 32'd11);
        rd("ecall.mstatus", 12'h300, 32'h80);
        sys_op("mret", 8'h20, 32'h304, 32'h3020_0073, 32'h300, 1'b0);
        rd("mret.mstatus", 12'h300, 32'h88);

        jcond_vld = 1'b1; jcond_pc = 32'h1234; #1;
        check("jcond", {30'd0, jump_valid, stage_id_clear, jump_pc}, {32'h3, 32'h1234});
        jcond_vld = 1'b0;

        sys_op("fencei", 8'h20, 32'h500, 32'h0000_100F, 32'h504, 1'b0);
        sys_op("wfi", 8'h20, 32'h704, 32'h1050_0073, 32'h1000, 1'b0);
        rd("wfi.mcause", 12'h342, 32'd2);
        rd("wfi.mepc", 12'h341, 32'h704);
        sys_op("illegal", 8'h24, 32'h600, 32'h0000_0073, 32'h1000, 1'b0);
        rd("illegal.mcause", 12'h342, 32'd2);
        rd("illegal.mepc", 12'h341, 32'h600);
        rd("illegal.mstatus", 12'h300, 32'h0);

        csr_op("tmr.mtvec", 12'h305, 3'd1, 32'h2001, 5'd0, 32'h1000);
        csr_op("tmr.cmplo", 12'h7C0, 3'd1, 32'd5, 5'd0, 32'hFFFF_FFFF);
        csr_op("tmr.cmphi", 12'h7C1, 3'd1, 32'd0, 5'd0, 32'hFFFF_FFFF);
        csr_op("tmr.mie", 12'h304, 3'd1, 32'h80, 5'd0, 32'h0);
        int_pc = 32'h400; int_ready = 1'b1;
        csr_op("tmr.en", 12'h300, 3'd6, 32'h0, 5'd8, 32'h0);
        wait_irq("tmr", 32'h201C);
        rd("tmr.mcause", 12'h342, 32'h8000_0007);
        rd("tmr.mepc", 12'h341, 32'h400);
        rd("tmr.mstatus", 12'h300, 32'h80);

        csr_op("pri.mie", 12'h304, 3'd1, 32'h000F_0080, 5'd0, 32'h80);
        irq_ext = 4'b0101; int_pc = 32'h440;
        csr_op("pri.en", 12'h300, 3'd6, 32'h0, 5'd8, 32'h80);
        hits = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (jump_valid) hits++;
        end
        check("pri.noready", 64'(hits), 64'd0);
        int_ready = 1'b1;
        wait_irq("pri", 32'h2040);
        irq_ext = '0;
        rd("pri.mcause", 12'h342, 32'h8000_0010);
        rd("pri.mepc", 12'h341, 32'h440);

        do_reset();
        for (int k = 0; k < 60; k++) begin
            a   = addrs[$urandom_range(0, 13)];
            f   = fsel[$urandom_range(0, 5)];
            rs1 = $urandom;
            u   = 5'($urandom);
            irq_ext = NIRQ'($urandom);
            exp = model_read(a);
            csr_op("rnd", a, f, rs1, u, exp);
            opnd = f[2] ? {27'd0, u} : rs1;
            case (f[1:0])
                2'd1:    w = opnd;
                2'd2:    w = exp | opnd;
                default: w = exp & ~opnd;
            endcase
            model_write(a, w);
        end
        irq_ext = '0;

        bus.req_valid    = 1'b1;
        bus.req_para     = 8'h10;
        bus.req_operand0 = 32'h1234_5678;
        bus.req_operand1 = {12'h340, 5'd0, 3'd1, 5'd1, 7'h73};
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0; #1;
        check("midrst.now", {62'd0, bus.ack_valid, bus.ack_busy}, 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst.ack", 64'(bus.ack_valid), 64'd0);
        end
        rst_n = 1'b1;
        check("midrst.jump", {30'd0, jump_valid, stage_id_clear, jump_pc}, {32'h3, 32'h200});
        @(posedge clk); #1;
        check("midrst.ack2", 64'(bus.ack_valid), 64'd0);
        rd("midrst.scr", 12'h340, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule
